// File: rtl/insn_prefetcher.sv
// Instruction prefetch unit: owns the fetch PC, issues one sequential fetch per cycle
// to a 1-cycle synchronous memory, and buffers tagged responses in a DEPTH-entry FIFO.
module insn_prefetcher #(
    parameter int                       LEN_INSN      = 32,
    parameter int                       MEM_INSN_ADDR = 10,
    parameter int                       DEPTH         = 4,
    parameter logic [MEM_INSN_ADDR-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_i,
    input  logic [MEM_INSN_ADDR-1:0] redirect_addr_i,
    output logic                     mem_en_o,
    output logic [MEM_INSN_ADDR-1:0] mem_addr_o,
    input  logic [LEN_INSN-1:0]      mem_q_i,
    output logic                     valid_o,
    input  logic                     stall_i,
    output logic [LEN_INSN-1:0]      insn_o,
    output logic [MEM_INSN_ADDR-1:0] pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [MEM_INSN_ADDR-1:0] pc_p0;
    logic                     inflight_p1;
    logic                     kill_p1;
    logic [MEM_INSN_ADDR-1:0] inflight_pc_p1;

    logic [LEN_INSN-1:0]      fifo_insn [DEPTH];
    logic [MEM_INSN_ADDR-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [CNT_W-1:0]         count;

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    // Credit check counts the word in flight and the word leaving this cycle, so a
    // stall release turns straight into a new fetch (stall_i -> mem_en_o is combinational).
    assign pop       = valid_o & ~stall_i;
    assign occupancy = {1'b0, count} + OCC_W'(inflight_p1) - OCC_W'(pop);
    assign issue     = ~rst & ~redirect_i & (occupancy < OCC_W'(DEPTH));
    assign push      = inflight_p1 & ~kill_p1 & ~redirect_i;

    assign mem_en_o   = issue;
    assign mem_addr_o = pc_p0;

    // Stage p0 -> p1: fetch issue, pointer and occupancy control
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0       <= RESET_PC;
            inflight_p1 <= 1'b0;
            kill_p1     <= 1'b0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect_i) begin
            pc_p0       <= redirect_addr_i;
            inflight_p1 <= 1'b0;
            if (inflight_p1) kill_p1 <= 1'b1;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
        end else begin
            if (issue) begin
                pc_p0       <= pc_p0 + MEM_INSN_ADDR'(1);
                inflight_p1 <= 1'b1;
                kill_p1     <= 1'b0;
            end else begin
                inflight_p1 <= 1'b0;
            end
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc_p1 <= pc_p0;
    end

    // Stage p1 -> FIFO: response capture tagged with its fetch address
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_insn[tail] <= mem_q_i;
            fifo_pc[tail]   <= inflight_pc_p1;
        end
    end

    assign valid_o = (count != '0);
    assign insn_o  = fifo_insn[head];
    assign pc_o    = fifo_pc[head];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_insn_prefetcher.sv
// Self-checking bench for insn_prefetcher: directed timing scenarios plus randomized
// traffic compared against a queue-based model of the fetch stream.
module tb_insn_prefetcher;

    localparam int             LEN   = 32;
    localparam int             AW    = 10;
    localparam int             DEPTH = 4;
    localparam logic [AW-1:0]  RPC   = 10'h3FE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            redirect_i;
    logic [AW-1:0]   redirect_addr_i;
    logic            mem_en_o;
    logic [AW-1:0]   mem_addr_o;
    logic [LEN-1:0]  mem_q_i;
    logic            valid_o;
    logic            stall_i;
    logic [LEN-1:0]  insn_o;
    logic [AW-1:0]   pc_o;

    int checks   = 0;
    int failures = 0;

    insn_prefetcher #(
        .LEN_INSN(LEN), .MEM_INSN_ADDR(AW), .DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_q_i(mem_q_i),
        .valid_o(valid_o), .stall_i(stall_i), .insn_o(insn_o), .pc_o(pc_o)
    );

    function automatic logic [LEN-1:0] mem_word(input logic [AW-1:0] a);
        return ({22'b0, a} * 32'h9E3779B1) ^ 32'h0000A5A5;
    endfunction

    // Reference model: queue of buffered fetch addresses, one pending fetch, next address.
    logic [AW-1:0]  q[$];
    bit             pend = 1'b0;
    logic [AW-1:0]  pend_pc = '0;
    logic [AW-1:0]  next_pc = RPC;
    bit             m_rst, m_redir, pop;
    logic [AW-1:0]  m_addr;
    bit             exp_valid, exp_en;
    logic [AW-1:0]  exp_pc, exp_addr;
    logic [LEN-1:0] exp_insn;
    logic           en_s;
    logic [AW-1:0]  addr_s;

    task automatic apply(input bit r, input bit rd, input logic [AW-1:0] a, input bit s);
        @(negedge clk);
        rst = r; redirect_i = rd; redirect_addr_i = a; stall_i = s;
        #1;
        exp_valid = (q.size() != 0);
        exp_pc    = exp_valid ? q[0] : '0;
        exp_insn  = mem_word(exp_pc);
        pop       = exp_valid && !s;
        exp_en    = !r && !rd && ((q.size() + int'(pend) - int'(pop)) < DEPTH);
        exp_addr  = next_pc;
        m_rst = r; m_redir = rd; m_addr = a;
        en_s = mem_en_o; addr_s = mem_addr_o;
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_rst) begin
            q.delete(); pend = 1'b0; next_pc = RPC;
        end else if (m_redir) begin
            q.delete(); pend = 1'b0; next_pc = m_addr;
        end else begin
            if (pop) void'(q.pop_front());
            if (pend) q.push_back(pend_pc);
            pend = exp_en;
            if (exp_en) begin
                pend_pc = next_pc;
                next_pc = next_pc + 10'd1;
            end
        end
        #1;
        mem_q_i = en_s ? mem_word(addr_s) : LEN'($urandom);
    endtask

    task automatic test_reset();
        logic [AW-1:0] e;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, '0, 1'b0);
            checks++;
            if (mem_en_o !== 1'b0) begin
                failures++; $display("FAIL reset_mem_en got=%b exp=0", mem_en_o);
            end
            if (i > 0) begin
                checks++;
                if (valid_o !== 1'b0) begin
                    failures++; $display("FAIL reset_valid got=%b exp=0", valid_o);
                end
            end
            advance();
        end
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            e = RPC + 10'(k);
            checks++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== e) begin
                failures++;
                $display("FAIL reset_fetch k=%0d got en=%b addr=%h exp en=1 addr=%h", k, mem_en_o, mem_addr_o, e);
            end
            checks++;
            if (valid_o !== (k >= 2)) begin
                failures++; $display("FAIL reset_valid_rise k=%0d got=%b exp=%b", k, valid_o, k >= 2);
            end
            if (k >= 2) begin
                e = RPC + 10'(k - 2);
                checks++;
                if (pc_o !== e || insn_o !== mem_word(e)) begin
                    failures++;
                    $display("FAIL reset_stream k=%0d got pc=%h insn=%h exp pc=%h insn=%h", k, pc_o, insn_o, e, mem_word(e));
                end
            end
            advance();
        end
    endtask

    task automatic test_stall_fill();
        logic [AW-1:0] e;
        apply(1'b0, 1'b1, 10'h010, 1'b1);
        advance();
        for (int k = 1; k <= 8; k++) begin
            apply(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (mem_en_o !== (k <= 4)) begin
                failures++; $display("FAIL fill_mem_en k=%0d got=%b exp=%b", k, mem_en_o, k <= 4);
            end
            if (k <= 4) begin
                e = 10'h010 + 10'(k - 1);
                checks++;
                if (mem_addr_o !== e) begin
                    failures++; $display("FAIL fill_addr k=%0d got=%h exp=%h", k, mem_addr_o, e);
                end
            end
            checks++;
            if (valid_o !== (k >= 3) || (k >= 3 && pc_o !== 10'h010)) begin
                failures++; $display("FAIL fill_head k=%0d got valid=%b pc=%h exp valid=%b pc=010", k, valid_o, pc_o, k >= 3);
            end
            advance();
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            e = 10'h010 + 10'(i);
            checks++;
            if (valid_o !== 1'b1 || pc_o !== e || insn_o !== mem_word(e)) begin
                failures++;
                $display("FAIL release_stream i=%0d got valid=%b pc=%h insn=%h exp valid=1 pc=%h insn=%h", i, valid_o, pc_o, insn_o, e, mem_word(e));
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        logic [AW-1:0] e;
        apply(1'b0, 1'b1, 10'h080, 1'b1);
        advance();
        for (int k = 1; k <= 4; k++) begin
            apply(1'b0, 1'b0, '0, 1'b1);
            advance();
        end
        // Three words buffered, one in flight; redirect while the head would pop.
        apply(1'b0, 1'b1, 10'h100, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 10'h080 || mem_en_o !== 1'b0) begin
            failures++; $display("FAIL redir_cycle got valid=%b pc=%h en=%b exp valid=1 pc=080 en=0", valid_o, pc_o, mem_en_o);
        end
        advance();
        for (int j = 1; j <= 5; j++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            e = 10'h100 + 10'(j - 1);
            checks++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== e) begin
                failures++; $display("FAIL redir_fetch j=%0d got en=%b addr=%h exp en=1 addr=%h", j, mem_en_o, mem_addr_o, e);
            end
            e = 10'h100 + 10'(j - 3);
            checks++;
            if (valid_o !== (j >= 3) || (j >= 3 && (pc_o !== e || insn_o !== mem_word(e)))) begin
                failures++;
                $display("FAIL redir_out j=%0d got valid=%b pc=%h insn=%h exp valid=%b pc=%h", j, valid_o, pc_o, insn_o, j >= 3, e);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] e;
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            advance();
        end
        apply(1'b0, 1'b1, 10'h020, 1'b0);
        checks++;
        if (mem_en_o !== 1'b0) begin
            failures++; $display("FAIL b2b_first_en got=%b exp=0", mem_en_o);
        end
        advance();
        apply(1'b0, 1'b1, 10'h040, 1'b0);
        checks++;
        if (mem_en_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++; $display("FAIL b2b_second got en=%b valid=%b exp en=0 valid=0", mem_en_o, valid_o);
        end
        advance();
        for (int j = 1; j <= 5; j++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            e = 10'h040 + 10'(j - 1);
            checks++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== e) begin
                failures++; $display("FAIL b2b_fetch j=%0d got en=%b addr=%h exp en=1 addr=%h", j, mem_en_o, mem_addr_o, e);
            end
            e = 10'h040 + 10'(j - 3);
            checks++;
            if (valid_o !== (j >= 3) || (j >= 3 && (pc_o !== e || insn_o !== mem_word(e)))) begin
                failures++;
                $display("FAIL b2b_out j=%0d got valid=%b pc=%h insn=%h exp valid=%b pc=%h", j, valid_o, pc_o, insn_o, j >= 3, e);
            end
            advance();
        end
    endtask

    task automatic test_rst_mid();
        logic [AW-1:0] e;
        apply(1'b0, 1'b1, 10'h200, 1'b0);
        advance();
        for (int k = 0; k < 6; k++) begin
            apply(1'b0, 1'b0, '0, (k >= 4));
            advance();
        end
        apply(1'b1, 1'b1, 10'h155, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || mem_en_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_cycle got valid=%b en=%b exp valid=1 en=0", valid_o, mem_en_o);
        end
        advance();
        for (int j = 1; j <= 5; j++) begin
            apply(1'b0, 1'b0, '0, 1'b0);
            e = RPC + 10'(j - 1);
            checks++;
            if (mem_en_o !== 1'b1 || mem_addr_o !== e) begin
                failures++; $display("FAIL rstmid_fetch j=%0d got en=%b addr=%h exp en=1 addr=%h", j, mem_en_o, mem_addr_o, e);
            end
            e = RPC + 10'(j - 3);
            checks++;
            if (valid_o !== (j >= 3) || (j >= 3 && (pc_o !== e || insn_o !== mem_word(e)))) begin
                failures++;
                $display("FAIL rstmid_out j=%0d got valid=%b pc=%h insn=%h exp valid=%b pc=%h", j, valid_o, pc_o, insn_o, j >= 3, e);
            end
            advance();
        end
    endtask

    task automatic test_random_mix();
        bit r, rd, s;
        int bias;
        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 0) bias = int'($urandom_range(0, 3));
            r  = ($urandom_range(0, 149) == 0);
            rd = ($urandom_range(0, 24) == 0);
            s  = (int'($urandom_range(0, 3)) < bias);
            apply(r, rd, AW'($urandom), s);
            checks++;
            if (valid_o !== exp_valid) begin
                failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, valid_o, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (pc_o !== exp_pc || insn_o !== exp_insn) begin
                    failures++;
                    $display("FAIL rand_head n=%0d got pc=%h insn=%h exp pc=%h insn=%h", n, pc_o, insn_o, exp_pc, exp_insn);
                end
            end
            checks++;
            if (mem_en_o !== exp_en) begin
                failures++; $display("FAIL rand_mem_en n=%0d got=%b exp=%b", n, mem_en_o, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (mem_addr_o !== exp_addr) begin
                    failures++; $display("FAIL rand_mem_addr n=%0d got=%h exp=%h", n, mem_addr_o, exp_addr);
                end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_addr_i = '0; stall_i = 1'b0; mem_q_i = '0;
        test_reset();
        test_stall_fill();
        test_redirect();
        test_back_to_back();
        test_rst_mid();
        test_random_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_prefetcher.md
# insn_prefetcher

Parametrised instruction prefetch unit that sits between the instruction memory and the decode stage. It owns the fetch PC and issues one sequential fetch per cycle to a 1-cycle-latency synchronous instruction memory. Returned instructions, tagged with their PC, are buffered in a DEPTH-entry FIFO so that downstream stalls never lose a word. A redirect input (branch/jump) flushes the buffer, kills any in-flight fetch and restarts fetching from a new address.

## Interface
- One clock; reset is synchronous and active-high.
- Parameters:
- LEN_INSN, 32, instruction width in bits
- MEM_INSN_ADDR, 10, instruction address width (word addresses)
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset
- Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- redirect_i  input  1  discard all buffered/in-flight words, restart at redirect_addr_i
- redirect_addr_i  input  MEM_INSN_ADDR  new fetch address
- mem_en_o  output  1  fetch issued this cycle
- mem_addr_o  output  MEM_INSN_ADDR  fetch address (equals internal pc)
- mem_q_i  input  LEN_INSN  memory data, valid the cycle after mem_en_o
- valid_o  output  1  FIFO head holds a valid instruction
- stall_i  input  1  downstream not accepting this cycle
- insn_o  output  LEN_INSN  head instruction
- pc_o  output  MEM_INSN_ADDR  address of head instruction

## Operation
- State: pc, inflight (fetch issued last cycle), inflight_pc, kill (in-flight response to drop), FIFO storage, head/tail pointers, count (0..DEPTH).
- pop = valid_o & ~stall_i.
- issue = ~rst & ~redirect_i & (count + inflight − pop < DEPTH). Combinational path stall_i → mem_en_o is intentional; it gives full 1 word/cycle throughput.
- On issue: mem_en_o=1, mem_addr_o=pc; pc ← pc+1 modulo 2^MEM_INSN_ADDR (wraps max→0); inflight ← 1, inflight_pc ← pc, kill ← 0. Otherwise inflight ← 0.
- Response: if inflight & ~kill & ~redirect_i, push {mem_q_i, inflight_pc} at tail.
- Push and pop in the same cycle: count unchanged, both pointers advance. Credit rule guarantees no push into a full FIFO; a push at count==DEPTH is a design error (assertion).
- Redirect (highest priority after rst): count ← 0, pointers ← 0, pc ← redirect_addr_i, no issue, no push, pop ignored; if inflight then kill ← 1 so the response next cycle is dropped. Back-to-back redirects: the last one wins.
- valid_o = (count ≠ 0); insn_o/pc_o driven from the head entry; undefined (don't-care) when valid_o=0.
- mem_en_o/mem_addr_o are don't-care while rst or redirect_i is high except mem_en_o must be 0.

## Timing
- Reset values (cycle after rst sampled high): valid_o=0, mem_en_o=0 while rst held, pc=RESET_PC, count=0, inflight=0, kill=0.
- First issue in first cycle with rst low (R); mem_q_i in R+1, pushed at end of R+1; valid_o=1 in R+2 with pc_o=RESET_PC.
- Redirect sampled in cycle T: valid_o=0 in T+1; first issue of redirect_addr_i in T+1; valid_o=1 with pc_o=redirect_addr_i in T+3.
- Streaming with stall_i=0: one instruction per cycle, consecutive pc_o.
- rst mid-operation overrides redirect and everything else; in-flight response in the following cycle is dropped (inflight cleared).
- Latency fetch→valid_o: 2 cycles with empty FIFO.

## Test plan
- Reset then stall_i=0, memory holds insn=addr^0xA5A5: valid_o rises at R+2, pc_o=0,1,2,… every cycle, insn_o matches, mem_en_o continuous.
- Hold stall_i=1 from R+2: FIFO fills to 4, mem_en_o drops once count+inflight=4; release stall: pc_o 0..3 then 4.. with no gap or duplicate.
- Redirect to 0x100 while 3 entries buffered and a fetch in flight: valid_o=0 next cycle, killed word never appears, valid_o at T+3 with pc_o=0x100, then 0x101.
- RESET_PC=0x3FE, MEM_INSN_ADDR=10: pc_o sequence 0x3FE,0x3FF,0x000,0x001.
- Redirect asserted with valid_o & ~stall_i same cycle, and redirect on two consecutive cycles (0x20 then 0x40): first output after is pc_o=0x40, nothing from 0x20.
- rst asserted for one cycle mid-stream with FIFO half full: valid_o=0 next cycle, restart from RESET_PC, no stale word emitted.
